// File: rtl/core_pkg.sv
// Shared core types: opcodes, ALU op encoding, immediate formats,
// control word and the decode-to-execute bundle.
package core_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int RIDX  = $clog2(NREGS);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_AND    = 4'd2,
    ALU_OR     = 4'd3,
    ALU_XOR    = 4'd4,
    ALU_SLL    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_SLT    = 4'd8,
    ALU_SLTU   = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_J    = 3'd4,
    IMM_U    = 3'd5
  } imm_fmt_e;

  typedef struct packed {
    alu_op_e alu_op;
    logic    alu_src_imm;
    logic    mem_read;
    logic    mem_write;
    logic    reg_write;
    logic    branch;
    logic    jump;
  } ctrl_t;

  typedef struct packed {
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc_plus_4;
    logic [RIDX-1:0] rd;
    ctrl_t           ctrl;
    logic            valid;
    logic            illegal;
  } id_ex_t;

  // Opcode bits are not needed here, only instr[31:7].
  function automatic logic [XLEN-1:0] imm_gen(
    input logic [31:7] i,
    input imm_fmt_e    f
  );
    logic [XLEN-1:0] r;
    r = '0;
    unique case (f)
      IMM_I: r = {{20{i[31]}}, i[31:20]};
      IMM_S: r = {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_B: r = {{19{i[31]}}, i[31], i[7],
                  i[30:25], i[11:8], 1'b0};
      IMM_J: r = {{11{i[31]}}, i[31], i[19:12],
                  i[20], i[30:21], 1'b0};
      IMM_U: r = {i[31:12], 12'b0};
      default: r = '0;
    endcase
    return r;
  endfunction

  // f7b5 selects SUB only for register ops; shifts use it in both.
  function automatic alu_op_e alu_decode(
    input logic [2:0] f3,
    input logic       f7b5,
    input logic       is_reg
  );
    alu_op_e r;
    r = ALU_ADD;
    unique case (f3)
      3'b000: r = (is_reg && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001: r = ALU_SLL;
      3'b010: r = ALU_SLT;
      3'b011: r = ALU_SLTU;
      3'b100: r = ALU_XOR;
      3'b101: r = f7b5 ? ALU_SRA : ALU_SRL;
      3'b110: r = ALU_OR;
      3'b111: r = ALU_AND;
      default: r = ALU_ADD;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/reg_file.sv
// Integer register file: two combinational reads, one synchronous
// write, x0 hardwired to zero, asynchronous clear.
module reg_file
  import core_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [RIDX-1:0] rs1_addr,
  input  logic [RIDX-1:0] rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            we,
  input  logic [RIDX-1:0] waddr,
  input  logic [XLEN-1:0] wdata
);

  logic [XLEN-1:0] regs [NREGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rs1_data = (rs1_addr == '0) ? '0 : regs[rs1_addr];
  assign rs2_data = (rs2_addr == '0) ? '0 : regs[rs2_addr];

endmodule

// File: rtl/decode_stage.sv
// Decode stage: register read, immediate and control decode, ID/EX reg.
// DECODE_WB_BYPASS_EN selects write-first operand capture.
module decode_stage
  import core_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     instr_in,
  input  logic [XLEN-1:0] pc_plus_4_in,
  input  logic            in_valid,
  input  logic            stall,
  input  logic            flush,
  input  logic            wb_en,
  input  logic [RIDX-1:0] wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic [XLEN-1:0] imm,
  output logic [RIDX-1:0] rd,
  output logic [3:0]      alu_op,
  output logic            alu_src_imm,
  output logic            mem_read,
  output logic            mem_write,
  output logic            reg_write,
  output logic            branch,
  output logic            jump,
  output logic [XLEN-1:0] pc_plus_4_out,
  output logic            out_valid,
  output logic            illegal
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            f7b5;
  logic [RIDX-1:0] rs1_idx;
  logic [RIDX-1:0] rs2_idx;
  logic [XLEN-1:0] rf_rs1;
  logic [XLEN-1:0] rf_rs2;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic            known;
  imm_fmt_e        fmt;
  ctrl_t           ctrl_d;
  id_ex_t          d;
  id_ex_t          q;

  assign opcode  = instr_in[6:0];
  assign funct3  = instr_in[14:12];
  assign f7b5    = instr_in[30];
  assign rs1_idx = instr_in[19:15];
  assign rs2_idx = instr_in[24:20];

  reg_file u_rf (
    .clk      (clk),
    .rst      (rst),
    .rs1_addr (rs1_idx),
    .rs2_addr (rs2_idx),
    .rs1_data (rf_rs1),
    .rs2_data (rf_rs2),
    .we       (wb_en),
    .waddr    (wb_addr),
    .wdata    (wb_data)
  );

`ifdef DECODE_WB_BYPASS_EN
  logic wb_live;
  assign wb_live = wb_en && (wb_addr != '0);
  assign op1 = (wb_live && wb_addr == rs1_idx)
             ? wb_data : rf_rs1;
  assign op2 = (wb_live && wb_addr == rs2_idx)
             ? wb_data : rf_rs2;
`else
  assign op1 = rf_rs1;
  assign op2 = rf_rs2;
`endif

  always_comb begin
    ctrl_d = '0;
    fmt    = IMM_NONE;
    known  = 1'b1;
    unique case (1'b1)
      (opcode == OP_R): begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_op    = alu_decode(funct3, f7b5, 1'b1);
      end
      (opcode == OP_IMM): begin
        fmt                = IMM_I;
        ctrl_d.reg_write   = 1'b1;
        ctrl_d.alu_src_imm = 1'b1;
        ctrl_d.alu_op      = alu_decode(funct3, f7b5, 1'b0);
      end
      (opcode == OP_LOAD): begin
        fmt                = IMM_I;
        ctrl_d.mem_read    = 1'b1;
        ctrl_d.reg_write   = 1'b1;
        ctrl_d.alu_src_imm = 1'b1;
        ctrl_d.alu_op      = ALU_ADD;
      end
      (opcode == OP_STORE): begin
        fmt                = IMM_S;
        ctrl_d.mem_write   = 1'b1;
        ctrl_d.alu_src_imm = 1'b1;
        ctrl_d.alu_op      = ALU_ADD;
      end
      (opcode == OP_BRANCH): begin
        fmt           = IMM_B;
        ctrl_d.branch = 1'b1;
        ctrl_d.alu_op = ALU_SUB;
      end
      (opcode == OP_JAL): begin
        fmt              = IMM_J;
        ctrl_d.jump      = 1'b1;
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_op    = ALU_ADD;
      end
      (opcode == OP_LUI): begin
        fmt                = IMM_U;
        ctrl_d.reg_write   = 1'b1;
        ctrl_d.alu_src_imm = 1'b1;
        ctrl_d.alu_op      = ALU_PASS_B;
      end
      default: known = 1'b0;
    endcase
    if (!in_valid || !known) begin
      ctrl_d = '0;
    end
  end

  always_comb begin
    d           = '0;
    d.rs1_data  = op1;
    d.rs2_data  = op2;
    d.imm       = imm_gen(instr_in[31:7], fmt);
    d.pc_plus_4 = pc_plus_4_in;
    d.rd        = instr_in[11:7];
    d.ctrl      = ctrl_d;
    d.valid     = in_valid && known;
    d.illegal   = in_valid && !known;
  end

  // Flush only kills the bubble-relevant fields; data may go stale.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (flush) begin
      q.ctrl    <= '0;
      q.valid   <= 1'b0;
      q.illegal <= 1'b0;
    end else if (!stall) begin
      q <= d;
    end
  end

  assign rs1_data      = q.rs1_data;
  assign rs2_data      = q.rs2_data;
  assign imm           = q.imm;
  assign rd            = q.rd;
  assign alu_op        = q.ctrl.alu_op;
  assign alu_src_imm   = q.ctrl.alu_src_imm;
  assign mem_read      = q.ctrl.mem_read;
  assign mem_write     = q.ctrl.mem_write;
  assign reg_write     = q.ctrl.reg_write;
  assign branch        = q.ctrl.branch;
  assign jump          = q.ctrl.jump;
  assign pc_plus_4_out = q.pc_plus_4;
  assign out_valid     = q.valid;
  assign illegal       = q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage; expectations hand-computed.
// Honors DECODE_WB_BYPASS_EN for the same-edge write case.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_in;
  logic [31:0] pc_plus_4_in;
  logic        in_valid;
  logic        stall;
  logic        flush;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] imm;
  logic [4:0]  rd;
  logic [3:0]  alu_op;
  logic        alu_src_imm;
  logic        mem_read;
  logic        mem_write;
  logic        reg_write;
  logic        branch;
  logic        jump;
  logic [31:0] pc_plus_4_out;
  logic        out_valid;
  logic        illegal;

  int checks = 0;
  int failures = 0;

  decode_stage dut (
    .clk           (clk),
    .rst           (rst),
    .instr_in      (instr_in),
    .pc_plus_4_in  (pc_plus_4_in),
    .in_valid      (in_valid),
    .stall         (stall),
    .flush         (flush),
    .wb_en         (wb_en),
    .wb_addr       (wb_addr),
    .wb_data       (wb_data),
    .rs1_data      (rs1_data),
    .rs2_data      (rs2_data),
    .imm           (imm),
    .rd            (rd),
    .alu_op        (alu_op),
    .alu_src_imm   (alu_src_imm),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .reg_write     (reg_write),
    .branch        (branch),
    .jump          (jump),
    .pc_plus_4_out (pc_plus_4_out),
    .out_valid     (out_valid),
    .illegal       (illegal)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] i, input logic v);
    instr_in = i;
    in_valid = v;
    tick();
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] v);
    wb_en   = 1'b1;
    wb_addr = a;
    wb_data = v;
    in_valid = 1'b0;
    tick();
    wb_en = 1'b0;
  endtask

  logic [31:0] same_edge_exp;

  initial begin
    rst = 1'b1;
    instr_in = '0;
    pc_plus_4_in = '0;
    in_valid = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    wb_en = 1'b0;
    wb_addr = '0;
    wb_data = '0;
    #2;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_illegal", {31'd0, illegal}, 32'd0);
    check("rst_alu_op", {28'd0, alu_op}, 32'd0);
    check("rst_imm", imm, 32'd0);
    tick();
    rst = 1'b0;

    // addi x1,x0,5
    pc_plus_4_in = 32'h0000_0008;
    issue(32'h00500093, 1'b1);
    check("addi_imm", imm, 32'd5);
    check("addi_rd", {27'd0, rd}, 32'd1);
    check("addi_rs1", rs1_data, 32'd0);
    check("addi_src", {31'd0, alu_src_imm}, 32'd1);
    check("addi_rw", {31'd0, reg_write}, 32'd1);
    check("addi_valid", {31'd0, out_valid}, 32'd1);
    check("addi_pc4", pc_plus_4_out, 32'h8);

    wb(5'd1, 32'd7);
    wb(5'd2, 32'd3);

    // add x3,x1,x2
    issue(32'h002081B3, 1'b1);
    check("add_rs1", rs1_data, 32'd7);
    check("add_rs2", rs2_data, 32'd3);
    check("add_op", {28'd0, alu_op}, 32'd0);
    check("add_src", {31'd0, alu_src_imm}, 32'd0);

    // sub x3,x1,x2
    issue(32'h402081B3, 1'b1);
    check("sub_op", {28'd0, alu_op}, 32'd1);

    // srai x4,x1,3
    issue(32'h4030D213, 1'b1);
    check("srai_op", {28'd0, alu_op}, 32'd7);

    // sw x2,8(x1)
    issue(32'h0020A423, 1'b1);
    check("sw_imm", imm, 32'd8);
    check("sw_mw", {31'd0, mem_write}, 32'd1);
    check("sw_rw", {31'd0, reg_write}, 32'd0);

    // beq x1,x2,-4
    issue(32'hFE208EE3, 1'b1);
    check("beq_imm", imm, 32'hFFFF_FFFC);
    check("beq_br", {31'd0, branch}, 32'd1);
    check("beq_op", {28'd0, alu_op}, 32'd1);

    // jal x1,8
    issue(32'h008000EF, 1'b1);
    check("jal_imm", imm, 32'd8);
    check("jal_jump", {31'd0, jump}, 32'd1);
    check("jal_rw", {31'd0, reg_write}, 32'd1);

    // lw x6,-1(x2): I-type sign extension
    issue(32'hFFF12303, 1'b1);
    check("lw_imm", imm, 32'hFFFF_FFFF);
    check("lw_mr", {31'd0, mem_read}, 32'd1);

    // lui x5,0x12345
    issue(32'h123452B7, 1'b1);
    check("lui_imm", imm, 32'h1234_5000);
    check("lui_op", {28'd0, alu_op}, 32'd10);
    check("lui_rd", {27'd0, rd}, 32'd5);

    issue(32'h0000007F, 1'b1);
    check("ill_flag", {31'd0, illegal}, 32'd1);
    check("ill_valid", {31'd0, out_valid}, 32'd0);
    check("ill_rw", {31'd0, reg_write}, 32'd0);

    // valid=0 gives a bubble
    issue(32'h123452B7, 1'b0);
    check("nv_valid", {31'd0, out_valid}, 32'd0);
    check("nv_rw", {31'd0, reg_write}, 32'd0);
    check("nv_ill", {31'd0, illegal}, 32'd0);

    // stall holds
    pc_plus_4_in = 32'h0000_0100;
    issue(32'h002081B3, 1'b1);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      pc_plus_4_in = 32'h200 + k;
      issue(32'h123452B7 + (k << 7), 1'b1);
      check("stl_valid", {31'd0, out_valid}, 32'd1);
      check("stl_op", {28'd0, alu_op}, 32'd0);
      check("stl_rd", {27'd0, rd}, 32'd3);
      check("stl_pc4", pc_plus_4_out, 32'h100);
      check("stl_imm", imm, 32'd0);
    end
    flush = 1'b1;
    issue(32'h002081B3, 1'b1);
    check("flush_valid", {31'd0, out_valid}, 32'd0);
    check("flush_rw", {31'd0, reg_write}, 32'd0);
    stall = 1'b0;
    flush = 1'b0;

    // x0 write dropped
    wb(5'd0, 32'hFFFF_FFFF);
    issue(32'h000001B3, 1'b1);
    check("x0_rs1", rs1_data, 32'd0);
    check("x0_rs2", rs2_data, 32'd0);

    // same-edge write and read of x1
`ifdef DECODE_WB_BYPASS_EN
    same_edge_exp = 32'hDEAD_BEEF;
`else
    same_edge_exp = 32'd7;
`endif
    wb_en = 1'b1;
    wb_addr = 5'd1;
    wb_data = 32'hDEAD_BEEF;
    issue(32'h002081B3, 1'b1);
    wb_en = 1'b0;
    check("same_rs1", rs1_data, same_edge_exp);
    check("same_rs2", rs2_data, 32'd3);
    issue(32'h002081B3, 1'b1);
    check("after_rs1", rs1_data, 32'hDEAD_BEEF);

    // async reset mid-stream
    rst = 1'b1;
    #1;
    check("arst_valid", {31'd0, out_valid}, 32'd0);
    check("arst_rs1", rs1_data, 32'd0);
    check("arst_rw", {31'd0, reg_write}, 32'd0);
    #1;
    rst = 1'b0;
    issue(32'h002081B3, 1'b0);
    check("post_bubble", {31'd0, out_valid}, 32'd0);
    issue(32'h002081B3, 1'b1);
    check("post_rs1", rs1_data, 32'd0);
    check("post_valid", {31'd0, out_valid}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
